// File: rtl/debounce_pkg.sv
// Shared types and constants for the keypad debounce controller.
package debounce_pkg;

    localparam int unsigned SYNC_STAGES = 2;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_WAIT   = 1'b1
    } state_t;

endpackage

// File: rtl/key_debounce.sv
// One key: two-flop synchronizer, stable/settle FSM and settle down-counter.
// Emits the debounced level plus one-cycle press/release strobes.
module key_debounce
    import debounce_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press,
    // 'release' is a reserved word, hence the short name.
    output logic rel
);

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_STABLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_STABLE: begin
                if (s != level_q) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (s == level_q || cnt_q == '0) begin
                    state_d = ST_STABLE;
                end
            end
        endcase
    end

    // Counter, level and strobe next values; counter only moves while settling and never wraps.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        unique case (state_q)
            ST_STABLE: begin
                cnt_d = CntMax;
            end
            ST_WAIT: begin
                if (s == level_q) begin
                    cnt_d = CntMax;
                end else if (cnt_q == '0) begin
                    level_d = s;
                    press_d = s;
                    rel_d   = ~s;
                    cnt_d   = CntMax;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= CntMax;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    // Output process.
    always_comb begin
        level = level_q;
        press = press_q;
        rel   = rel_q;
    end

endmodule

// File: rtl/keypad_debounce.sv
// Multi-key debounce controller: per-key debouncers feeding a lowest-index
// priority stage that drives note index and note-on/note-off strobes.
module keypad_debounce
    import debounce_pkg::*;
#(
    parameter  int unsigned N_KEYS = 8,
    parameter  int unsigned CNT_W  = 16,
    localparam int unsigned IDX_W  = $clog2(N_KEYS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic              note_valid,
    output logic [IDX_W-1:0]  note_idx,
    output logic              note_on,
    output logic              note_off
);

    if (N_KEYS < 2 || N_KEYS > 16) begin : g_bad_n_keys
        $error("keypad_debounce: N_KEYS must be in 2..16");
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_debounce #(
            .CNT_W(CNT_W)
        ) u_key_debounce (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (key_raw[i]),
            .level(key_level[i]),
            .press(key_press[i]),
            .rel  (key_release[i])
        );
    end

    logic             valid_c;
    logic [IDX_W-1:0] idx_c;
    logic             valid_q;
    logic [IDX_W-1:0] idx_q;
    logic             on_q, on_d;
    logic             off_q, off_d;

    // Scan from the top so the lowest set bit wins; index stays 0 when nothing is held.
    always_comb begin
        idx_c = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (key_level[i]) begin
                idx_c = IDX_W'(i);
            end
        end
    end

    assign valid_c = |key_level;

    always_comb begin
        on_d  = valid_c & (~valid_q | (idx_c != idx_q));
        off_d = valid_q & ~valid_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            on_q    <= 1'b0;
            off_q   <= 1'b0;
        end else begin
            valid_q <= valid_c;
            idx_q   <= idx_c;
            on_q    <= on_d;
            off_q   <= off_d;
        end
    end

    assign note_valid = valid_q;
    assign note_idx   = idx_q;
    assign note_on    = on_q;
    assign note_off   = off_q;

endmodule

// File: tb/tb_keypad_debounce.sv
// Scoreboard bench for keypad_debounce with CNT_W=4, N_KEYS=8.
module tb_keypad_debounce;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] key_raw;
    logic [7:0] key_level;
    logic [7:0] key_press;
    logic [7:0] key_release;
    logic       note_valid;
    logic [2:0] note_idx;
    logic       note_on;
    logic       note_off;

    keypad_debounce #(
        .N_KEYS(8),
        .CNT_W (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_raw    (key_raw),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .note_valid (note_valid),
        .note_idx   (note_idx),
        .note_on    (note_on),
        .note_off   (note_off)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] press;
        logic [7:0] rel;
        logic [7:0] level;
        logic       on;
        logic       off;
        logic       valid;
        logic [2:0] idx;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  checks   = 0;
    int  failures = 0;

    // A raw change driven just after edge e commits at edge e+19; the note stage follows at e+20.
    task automatic commit(input int e, input logic [7:0] p, input logic [7:0] r,
                          input logic [7:0] lvl, input logic old_v, input logic [2:0] old_idx,
                          input logic on, input logic off, input logic new_v,
                          input logic [2:0] new_idx);
        ev_t ev;
        ev.cyc = e + 19; ev.press = p; ev.rel = r; ev.level = lvl;
        ev.on = 1'b0; ev.off = 1'b0; ev.valid = old_v; ev.idx = old_idx;
        exp_q.push_back(ev);
        if (on || off) begin
            ev.cyc = e + 20; ev.press = '0; ev.rel = '0;
            ev.on = on; ev.off = off; ev.valid = new_v; ev.idx = new_idx;
            exp_q.push_back(ev);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every strobe cycle must match the head of the queue; a passed head is a miss.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if ((|key_press) || (|key_release) || note_on || note_off) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_strobe cyc=%0d press=%h rel=%h on=%b off=%b",
                             cyc, key_press, key_release, note_on, note_off);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (cyc != mon_e.cyc || key_press !== mon_e.press ||
                        key_release !== mon_e.rel || key_level !== mon_e.level ||
                        note_on !== mon_e.on || note_off !== mon_e.off ||
                        note_valid !== mon_e.valid || note_idx !== mon_e.idx) begin
                        failures++;
                        $display({"FAIL event actual cyc=%0d press=%h rel=%h lvl=%h on=%b off=%b",
                                  " v=%b idx=%0d required cyc=%0d press=%h rel=%h lvl=%h on=%b",
                                  " off=%b v=%b idx=%0d"},
                                 cyc, key_press, key_release, key_level, note_on, note_off,
                                 note_valid, note_idx, mon_e.cyc, mon_e.press, mon_e.rel,
                                 mon_e.level, mon_e.on, mon_e.off, mon_e.valid, mon_e.idx);
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                failures++;
                mon_e = exp_q.pop_front();
                $display("FAIL missed_event actual=none required_cyc=%0d now=%0d",
                         mon_e.cyc, cyc);
            end
        end
    end

    task automatic edge_drive(input logic [7:0] val, output int e);
        @(posedge clk);
        #1;
        key_raw = val;
        e = cyc;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_level"}, 32'(key_level), 32'h0);
        chk({tag, "_press"}, 32'(key_press), 32'h0);
        chk({tag, "_release"}, 32'(key_release), 32'h0);
        chk({tag, "_valid"}, 32'(note_valid), 32'h0);
        chk({tag, "_idx"}, 32'(note_idx), 32'h0);
        chk({tag, "_on"}, 32'(note_on), 32'h0);
        chk({tag, "_off"}, 32'(note_off), 32'h0);
    endtask

    initial begin
        int e;
        rst_n   = 1'b0;
        key_raw = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        key_raw = 8'h00;
        rst_n   = 1'b1;
        repeat (100) @(posedge clk);

        // Clean press of key 3.
        edge_drive(8'h08, e);
        commit(e, 8'h08, 8'h00, 8'h08, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 3'd3);
        repeat (30) @(posedge clk);

        // Key 5 bounces every 5 cycles, final toggle leaves it high.
        for (int i = 0; i <= 12; i++) begin
            edge_drive((i % 2 == 0) ? 8'h28 : 8'h08, e);
            if (i < 12) repeat (4) @(posedge clk);
        end
        commit(e, 8'h20, 8'h00, 8'h28, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 3'd3);
        repeat (30) @(posedge clk);

        // Key 1 takes priority, then hands back to key 3.
        edge_drive(8'h2A, e);
        commit(e, 8'h02, 8'h00, 8'h2A, 1'b1, 3'd3, 1'b1, 1'b0, 1'b1, 3'd1);
        repeat (30) @(posedge clk);
        edge_drive(8'h28, e);
        commit(e, 8'h00, 8'h02, 8'h28, 1'b1, 3'd1, 1'b1, 1'b0, 1'b1, 3'd3);
        repeat (30) @(posedge clk);

        // Release everything held.
        edge_drive(8'h00, e);
        commit(e, 8'h00, 8'h28, 8'h00, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 3'd0);
        repeat (30) @(posedge clk);

        // Hold key 0, then reset while key 2 is mid-settle (cnt=7 after edge e+11).
        edge_drive(8'h01, e);
        commit(e, 8'h01, 8'h00, 8'h01, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 3'd0);
        repeat (30) @(posedge clk);
        edge_drive(8'h05, e);
        repeat (11) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("midsettle_reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        e = cyc;
        commit(e, 8'h05, 8'h00, 8'h05, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 3'd0);
        repeat (30) @(posedge clk);

        edge_drive(8'h00, e);
        commit(e, 8'h00, 8'h05, 8'h00, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 3'd0);
        repeat (30) @(posedge clk);

        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
